bb_mem_arbiter: RTL and testbench
=================================

# bb_mem_arbiter

Parametrised successor to the single-port memory controller. Sits between N_CH requester ports (instruction IO skin, data/other ports, future DMA) and the single external memory interface. It arbitrates round-robin among channels, issues one memory access at a time, and waits a configurable read latency before capturing read data. Each request is acknowledged with a one-cycle pulse on the requesting channel.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- N_CH, 2, number of requester channels, 1..8.
- RD_LAT, 1, cycles from the mem_r_en cycle to the mem_r_data valid cycle, 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; one clock, reset synchronous, active-low.
- i_ren  in  N_CH  per-channel read request, level.
- i_wen  in  N_CH  per-channel write request, level.
- i_addr  in  N_CH*ADDR_WIDTH  channel k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_data  in  N_CH*DATA_WIDTH  write data, channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- o_data  out  DATA_WIDTH  last captured read data, shared by all channels.
- o_ack  out  N_CH  one-hot completion pulse.
- o_busy  out  1  high whenever state != IDLE.
- mem_r_data  in  DATA_WIDTH  memory read data.
- mem_w_data  out  DATA_WIDTH  memory write data.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_r_en  out  1  memory read strobe.
- mem_w_en  out  1  memory write strobe.

## Operation
- All outputs are registered. Reset values: o_data=0, o_ack=0, o_busy=0, mem_w_data=0, mem_addr=0, mem_r_en=0, mem_w_en=0, state=IDLE, rr pointer=0, latency counter=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: a channel k is active if i_ren[k] or i_wen[k] is set. The winner is the first active channel searching from ptr upward, wrapping modulo N_CH. The block latches the winner's index, address, write data and op, sets ptr=(k+1) mod N_CH, and goes to ISSUE. With no active channel it stays in IDLE.
- Op select: if i_wen[k] is set, the op is a write, regardless of i_ren[k]. Otherwise the op is a read.
- ISSUE: exactly one of mem_w_en or mem_r_en is high for exactly one cycle, with mem_addr (and mem_w_data for writes) set to the latched values. A write goes to DONE. A read loads the counter with RD_LAT and goes to WAIT.
- WAIT: the counter decrements each cycle. On the cycle when mem_r_data is valid (RD_LAT cycles after the ISSUE cycle), o_data captures mem_r_data at the end of that cycle, and the FSM goes to DONE.
- DONE: o_ack[k] is high for one cycle, then the FSM returns to IDLE. No arbitration happens in DONE.
- mem_addr and mem_w_data hold their last issued values between accesses. o_data changes only on a read capture or reset.
- Requester rules:
  - Hold request, address and data stable until its o_ack bit pulses.
  - Drop the request at the edge ending the ack cycle, or keep it asserted to post a new request, which is arbitrated fairly in the following IDLE cycle.

## Timing
- Request visible in cycle 0 (IDLE). ISSUE in cycle 1.
- Write: mem_w_en in cycle 1, o_ack in cycle 2, back in IDLE in cycle 3.
- Read: mem_r_en in cycle 1, mem_r_data sampled in cycle 1+RD_LAT, o_ack and new o_data in cycle 2+RD_LAT.
- Throughput per channel-switch: 3 cycles per write, 3+RD_LAT cycles per read.
- Synchronous reset: at an edge with rst_n=0, any in-flight access is abandoned. All outputs are at reset values in the next cycle, no o_ack is issued for the abandoned access, and late mem_r_data is ignored.
- N_CH=1: the pointer is constant 0 and behaviour is otherwise identical.

## Test plan
- Reset: rst_n=0 for 2 cycles with i_wen=2'b11 -> all outputs 0 throughout, with no mem strobes. After release, ch0 is granted first.
- Single write: ch0 with addr 0x10 and data 0xDEADBEEF in cycle 0 -> mem_w_en=1, mem_addr=0x10, mem_w_data=0xDEADBEEF in cycle 1 only; o_ack=2'b01 in cycle 2.
- Read with RD_LAT=3: ch1 with addr 0x20, memory model returns 0x12345678 -> mem_r_en in cycle 1, o_ack=2'b10 and o_data=0x12345678 in cycle 5.
- Fairness with N_CH=4: all four channels hold continuous writes -> grant order 0,1,2,3,0,… with no channel acked twice consecutively. With only ch0 and ch2 active, the order alternates 0,2,0,2.
- ren+wen conflict: ch0 asserts i_ren=1 and i_wen=1 -> exactly one mem_w_en pulse, no mem_r_en, and o_data unchanged.
- Reset in WAIT: RD_LAT=4, rst_n=0 for one cycle during WAIT -> no o_ack and o_data=0. The next request from ch1 (with ch0 also active) is granted to ch0 first.

Source files
------------

// File: rtl/bb_mem_arbiter_if.sv
// bb_mem_arbiter_if
//   Bundles the requester-side and memory-side signals of bb_mem_arbiter.
//   Requester side: per-channel read/write requests, packed address and
//   write-data buses, shared read-data return, one-hot completion pulse and
//   a busy flag. Memory side: address, write data, read/write strobes and
//   returned read data.
//   Modports:
//     slave  - the arbiter's view (drives o_* and mem_* outputs)
//     master - the environment's view (requesters plus external memory)
interface bb_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_CH       = 2
);
  logic [N_CH-1:0]            i_ren;
  logic [N_CH-1:0]            i_wen;
  logic [N_CH*ADDR_WIDTH-1:0] i_addr;
  logic [N_CH*DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0]      o_data;
  logic [N_CH-1:0]            o_ack;
  logic                       o_busy;
  logic [DATA_WIDTH-1:0]      mem_r_data;
  logic [DATA_WIDTH-1:0]      mem_w_data;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic                       mem_r_en;
  logic                       mem_w_en;

  modport slave (
    input  i_ren, i_wen, i_addr, i_data, mem_r_data,
    output o_data, o_ack, o_busy, mem_w_data, mem_addr, mem_r_en, mem_w_en
  );

  modport master (
    output i_ren, i_wen, i_addr, i_data, mem_r_data,
    input  o_data, o_ack, o_busy, mem_w_data, mem_addr, mem_r_en, mem_w_en
  );
endinterface

// File: rtl/bb_mem_arbiter.sv
// bb_mem_arbiter
//   Round-robin arbiter in front of a single external memory port. One access
//   is in flight at a time: IDLE picks a winner, ISSUE pulses one strobe,
//   WAIT counts down the read latency, DONE pulses the winner's ack bit.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - synchronous, active-low reset
//     bus    - bb_mem_arbiter_if.slave (requester channels + memory port)
//   Parameters: DATA_WIDTH, ADDR_WIDTH, N_CH (1..8), RD_LAT (1..15).
module bb_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_CH       = 2,
  parameter int RD_LAT     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bb_mem_arbiter_if.slave bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic                  op_wr_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] o_data_q;
  logic [DATA_WIDTH-1:0] mem_w_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [N_CH-1:0]       o_ack_q;
  logic                  o_busy_q;
  logic                  mem_r_en_q;
  logic                  mem_w_en_q;

  logic [N_CH-1:0]       active;
  logic [ADDR_WIDTH-1:0] ch_addr [N_CH];
  logic [DATA_WIDTH-1:0] ch_data [N_CH];
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      ptr_d;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign active[gi]  = bus.i_ren[gi] | bus.i_wen[gi];
    assign ch_addr[gi] = bus.i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign ch_data[gi] = bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // First active channel at or above ptr_q, wrapping back to channel 0.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int j = 0; j < N_CH; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = IDX_W'(idx);
      if (!win_found && active[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    if (int'(win_idx) == N_CH - 1) ptr_d = '0;
    else                           ptr_d = win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      op_wr_q      <= 1'b0;
      cnt_q        <= '0;
      o_data_q     <= '0;
      mem_w_data_q <= '0;
      mem_addr_q   <= '0;
      o_ack_q      <= '0;
      o_busy_q     <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
    end else begin
      // Strobes and ack are single-cycle pulses unless re-asserted below.
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      o_ack_q    <= '0;
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q    <= win_idx;
            ptr_q      <= ptr_d;
            op_wr_q    <= bus.i_wen[win_idx];
            mem_addr_q <= ch_addr[win_idx];
            // Write wins over a simultaneous read request on the same channel.
            if (bus.i_wen[win_idx]) begin
              mem_w_data_q <= ch_data[win_idx];
              mem_w_en_q   <= 1'b1;
            end else begin
              mem_r_en_q <= 1'b1;
            end
            o_busy_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_wr_q) begin
            o_ack_q <= N_CH'(1) << grant_q;
            state_q <= DONE;
          end else begin
            cnt_q   <= 4'(RD_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // cnt_q reaches 1 exactly RD_LAT cycles after the ISSUE cycle.
          if (cnt_q == 4'd1) begin
            o_data_q <= bus.mem_r_data;
            o_ack_q  <= N_CH'(1) << grant_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          o_busy_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.o_ack      = o_ack_q;
  assign bus.o_busy     = o_busy_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_r_en   = mem_r_en_q;
  assign bus.mem_w_en   = mem_w_en_q;
endmodule

// File: tb/tb_bb_mem_arbiter.sv
module tb_bb_mem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NCH = 4;
  localparam int RDL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // memory model state
  logic          rd_pend = 1'b0;
  int            rd_cyc  = 0;
  logic [AW-1:0] rd_addr = '0;

  // reference model state
  int            ptr_m   = 0;
  logic [DW-1:0] odata_m = '0;
  logic [DW-1:0] wdata_m = '0;

  bb_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CH(NCH)) bus ();

  bb_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CH(NCH), .RD_LAT(RDL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    if (a == 32'h20) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // External memory: read data is valid only RDL cycles after the strobe
  // cycle; every other cycle carries junk.
  always @(negedge clk) begin
    if (rd_pend && cyc == rd_cyc + RDL) begin
      bus.mem_r_data = memval(rd_addr);
      rd_pend = 1'b0;
    end else begin
      bus.mem_r_data = $urandom;
    end
    if (bus.mem_r_en === 1'b1) begin
      rd_pend = 1'b1;
      rd_cyc  = cyc;
      rd_addr = bus.mem_addr;
    end
  end

  task automatic clr_req();
    bus.i_ren  = '0;
    bus.i_wen  = '0;
    bus.i_addr = '0;
    bus.i_data = '0;
  endtask

  task automatic set_ch(input int ch, input bit r, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_ren[ch]           = r;
    bus.i_wen[ch]           = w;
    bus.i_addr[ch*AW +: AW] = a;
    bus.i_data[ch*DW +: DW] = d;
  endtask

  // Leaves the bench at the negedge of an IDLE cycle straight after reset.
  task automatic do_reset();
    clr_req();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    ptr_m   = 0;
    odata_m = '0;
    wdata_m = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_req();
    set_ch(0, 1'b0, 1'b1, 32'h100, 32'hAAAA0000);
    set_ch(1, 1'b0, 1'b1, 32'h104, 32'hBBBB1111);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.o_ack, bus.o_busy, bus.mem_r_en, bus.mem_w_en} !== '0 ||
          bus.o_data !== '0 || bus.mem_addr !== '0 || bus.mem_w_data !== '0) begin
        failures++;
        $display("FAIL reset_outputs: ack=%b busy=%b ren=%b wen=%b data=%h addr=%h wdata=%h required all zero",
                 bus.o_ack, bus.o_busy, bus.mem_r_en, bus.mem_w_en, bus.o_data, bus.mem_addr, bus.mem_w_data);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_w_en, bus.mem_r_en} !== 2'b10 || bus.mem_addr !== 32'h100 ||
        bus.mem_w_data !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL reset_first_grant: wen/ren=%b%b addr=%h wdata=%h required 10 100 aaaa0000",
               bus.mem_w_en, bus.mem_r_en, bus.mem_addr, bus.mem_w_data);
    end
    @(negedge clk);
    checks++;
    if (bus.o_ack !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_ack: ack=%b required 0001", bus.o_ack);
    end
    clr_req();
    @(negedge clk);
    $display("reset: ch0 granted first after release");
  endtask

  task automatic test_single_write();
    do_reset();
    set_ch(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({bus.mem_w_en, bus.mem_r_en, bus.o_busy, bus.o_ack} !== 7'b1010000 ||
        bus.mem_addr !== 32'h10 || bus.mem_w_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_issue: wen=%b ren=%b busy=%b ack=%b addr=%h wdata=%h required 1 0 1 0000 10 deadbeef",
               bus.mem_w_en, bus.mem_r_en, bus.o_busy, bus.o_ack, bus.mem_addr, bus.mem_w_data);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_w_en, bus.mem_r_en, bus.o_busy, bus.o_ack} !== 7'b0010001) begin
      failures++;
      $display("FAIL write_ack: wen=%b ren=%b busy=%b ack=%b required 0 0 1 0001",
               bus.mem_w_en, bus.mem_r_en, bus.o_busy, bus.o_ack);
    end
    clr_req();
    @(negedge clk);
    checks++;
    if ({bus.mem_w_en, bus.o_busy, bus.o_ack} !== 6'b0 || bus.mem_addr !== 32'h10 ||
        bus.mem_w_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_idle_hold: wen=%b busy=%b ack=%b addr=%h wdata=%h required 0 0 0000 10 deadbeef",
               bus.mem_w_en, bus.o_busy, bus.o_ack, bus.mem_addr, bus.mem_w_data);
    end
    $display("txn single_write ch=0 addr=00000010 data=deadbeef");
  endtask

  task automatic test_read();
    do_reset();
    set_ch(1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.mem_r_en, bus.mem_w_en} !== 2'b10 || bus.mem_addr !== 32'h20 || bus.mem_w_data !== '0) begin
      failures++;
      $display("FAIL read_issue: ren=%b wen=%b addr=%h wdata=%h required 1 0 20 0",
               bus.mem_r_en, bus.mem_w_en, bus.mem_addr, bus.mem_w_data);
    end
    for (int i = 0; i < RDL; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_ack, bus.mem_r_en, bus.mem_w_en, bus.o_busy} !== 7'b0000001 || bus.o_data !== '0) begin
        failures++;
        $display("FAIL read_wait%0d: ack=%b ren=%b wen=%b busy=%b data=%h required 0000 0 0 1 0",
                 i, bus.o_ack, bus.mem_r_en, bus.mem_w_en, bus.o_busy, bus.o_data);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.o_ack !== 4'b0010 || bus.o_data !== 32'h12345678) begin
      failures++;
      $display("FAIL read_ack: ack=%b data=%h required 0010 12345678", bus.o_ack, bus.o_data);
    end
    clr_req();
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_ack !== '0) begin
      failures++;
      $display("FAIL read_idle: busy=%b ack=%b required 0 0000", bus.o_busy, bus.o_ack);
    end
    $display("txn read ch=1 addr=00000020 data=%h", bus.o_data);
  endtask

  // Runs straight after test_read, so o_data holds 0x12345678.
  task automatic test_conflict();
    int nw;
    int nr;
    logic [NCH-1:0] ack_seen;
    nw = 0;
    nr = 0;
    ack_seen = '0;
    set_ch(0, 1'b1, 1'b1, 32'h40, 32'h5555AAAA);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      nw += int'(bus.mem_w_en);
      nr += int'(bus.mem_r_en);
      if (bus.o_ack !== '0) begin
        ack_seen = bus.o_ack;
        clr_req();
      end
    end
    clr_req();
    checks++;
    if (nw != 1 || nr != 0) begin
      failures++;
      $display("FAIL conflict_strobes: w_pulses=%0d r_pulses=%0d required 1 0", nw, nr);
    end
    checks++;
    if (ack_seen !== 4'b0001 || bus.mem_w_data !== 32'h5555AAAA) begin
      failures++;
      $display("FAIL conflict_ack: ack=%b wdata=%h required 0001 5555aaaa", ack_seen, bus.mem_w_data);
    end
    checks++;
    if (bus.o_data !== 32'h12345678) begin
      failures++;
      $display("FAIL conflict_odata: data=%h required 12345678", bus.o_data);
    end
    $display("txn conflict ch=0 ren+wen -> write");
  endtask

  task automatic test_fairness();
    int t;
    logic [NCH-1:0] exp;
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 1'b1, 32'h200 + 32'(c * 4), $urandom);
    for (int n = 0; n < 8; n++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (bus.o_ack === '0 && t < 12);
      exp = 4'b0001 << (n % 4);
      checks++;
      if (bus.o_ack !== exp) begin
        failures++;
        $display("FAIL fair_all_%0d: ack=%b required %b", n, bus.o_ack, exp);
      end
      $display("txn fair_all n=%0d ack=%b", n, bus.o_ack);
    end
    do_reset();
    set_ch(0, 1'b0, 1'b1, 32'h300, 32'h1);
    set_ch(2, 1'b0, 1'b1, 32'h308, 32'h2);
    for (int n = 0; n < 4; n++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (bus.o_ack === '0 && t < 12);
      exp = (n % 2 == 1) ? 4'b0100 : 4'b0001;
      checks++;
      if (bus.o_ack !== exp) begin
        failures++;
        $display("FAIL fair_02_%0d: ack=%b required %b", n, bus.o_ack, exp);
      end
      $display("txn fair_02 n=%0d ack=%b", n, bus.o_ack);
    end
    clr_req();
  endtask

  task automatic test_reset_in_wait();
    int t;
    do_reset();
    set_ch(1, 1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_r_en !== 1'b1 || bus.mem_addr !== 32'h30) begin
      failures++;
      $display("FAIL rstwait_issue: ren=%b addr=%h required 1 30", bus.mem_r_en, bus.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    set_ch(0, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.o_ack, bus.o_busy, bus.mem_r_en, bus.mem_w_en} !== '0 || bus.o_data !== '0) begin
      failures++;
      $display("FAIL rstwait_reset: ack=%b busy=%b ren=%b wen=%b data=%h required all zero",
               bus.o_ack, bus.o_busy, bus.mem_r_en, bus.mem_w_en, bus.o_data);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_r_en !== 1'b1 || bus.mem_addr !== 32'h44) begin
      failures++;
      $display("FAIL rstwait_regrant: ren=%b addr=%h required 1 44", bus.mem_r_en, bus.mem_addr);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (bus.o_ack === '0 && t < 12);
    checks++;
    if (bus.o_ack !== 4'b0001 || bus.o_data !== memval(32'h44)) begin
      failures++;
      $display("FAIL rstwait_ack0: ack=%b data=%h required 0001 %h", bus.o_ack, bus.o_data, memval(32'h44));
    end
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0);
    t = 0;
    do begin @(negedge clk); t++; end while (bus.o_ack === '0 && t < 12);
    checks++;
    if (bus.o_ack !== 4'b0010 || bus.o_data !== memval(32'h30)) begin
      failures++;
      $display("FAIL rstwait_ack1: ack=%b data=%h required 0010 %h", bus.o_ack, bus.o_data, memval(32'h30));
    end
    clr_req();
    @(negedge clk);
    $display("txn reset_in_wait: ch0 then ch1 after abandoned read");
  endtask

  task automatic test_random();
    bit             v    [NCH];
    int             kind [NCH];   // 0 read, 1 write, 2 read+write (write)
    logic [AW-1:0]  a    [NCH];
    logic [DW-1:0]  d    [NCH];
    int             w;
    int             c;
    bit             wr;
    logic [NCH-1:0] exp_ack;
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      v[i] = 1'b1; kind[i] = $urandom_range(0, 2);
      a[i] = $urandom & 32'hFFFC; d[i] = $urandom;
    end
    for (int n = 0; n < 80; n++) begin
      // negedge of an IDLE cycle
      checks++;
      if ({bus.o_busy, bus.o_ack, bus.mem_r_en, bus.mem_w_en} !== '0) begin
        failures++;
        $display("FAIL rnd_idle_%0d: busy=%b ack=%b ren=%b wen=%b required all zero",
                 n, bus.o_busy, bus.o_ack, bus.mem_r_en, bus.mem_w_en);
      end
      for (int i = 0; i < NCH; i++)
        set_ch(i, v[i] && kind[i] != 1, v[i] && kind[i] != 0, a[i], d[i]);
      w = -1;
      for (int j = 0; j < NCH; j++) begin
        c = (ptr_m + j) % NCH;
        if (w < 0 && v[c]) w = c;
      end
      if (w < 0) begin
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
          if ($urandom_range(0, 1) == 1) begin
            v[i] = 1'b1; kind[i] = $urandom_range(0, 2);
            a[i] = $urandom & 32'hFFFC; d[i] = $urandom;
          end
        $display("txn rnd n=%0d none active", n);
        continue;
      end
      wr    = (kind[w] != 0);
      ptr_m = (w + 1) % NCH;
      if (wr) wdata_m = d[w];
      @(negedge clk);
      checks++;
      if (bus.mem_w_en !== wr || bus.mem_r_en !== !wr || bus.mem_addr !== a[w] ||
          bus.mem_w_data !== wdata_m || bus.o_ack !== '0 || bus.o_busy !== 1'b1) begin
        failures++;
        $display("FAIL rnd_issue_%0d: wen=%b ren=%b addr=%h wdata=%h ack=%b busy=%b required %b %b %h %h 0000 1",
                 n, bus.mem_w_en, bus.mem_r_en, bus.mem_addr, bus.mem_w_data, bus.o_ack, bus.o_busy,
                 wr, !wr, a[w], wdata_m);
      end
      if (!wr) begin
        for (int i = 0; i < RDL; i++) begin
          @(negedge clk);
          checks++;
          if ({bus.o_ack, bus.mem_r_en, bus.mem_w_en} !== '0 || bus.o_busy !== 1'b1 ||
              bus.o_data !== odata_m) begin
            failures++;
            $display("FAIL rnd_wait_%0d: ack=%b ren=%b wen=%b busy=%b data=%h required 0000 0 0 1 %h",
                     n, bus.o_ack, bus.mem_r_en, bus.mem_w_en, bus.o_busy, bus.o_data, odata_m);
          end
        end
        odata_m = memval(a[w]);
      end
      @(negedge clk);
      exp_ack = 4'b0001 << w;
      checks++;
      if (bus.o_ack !== exp_ack || bus.o_data !== odata_m || bus.o_busy !== 1'b1 ||
          {bus.mem_r_en, bus.mem_w_en} !== 2'b00) begin
        failures++;
        $display("FAIL rnd_done_%0d: ack=%b data=%h busy=%b ren/wen=%b%b required %b %h 1 00",
                 n, bus.o_ack, bus.o_data, bus.o_busy, bus.mem_r_en, bus.mem_w_en, exp_ack, odata_m);
      end
      $display("txn rnd n=%0d ch=%0d op=%s addr=%h data=%h", n, w, wr ? "WR" : "RD", a[w],
               wr ? d[w] : odata_m);
      for (int i = 0; i < NCH; i++) begin
        if ((i == w && $urandom_range(0, 1) == 1) || (i != w && !v[i] && $urandom_range(0, 2) == 0)) begin
          v[i] = 1'b1; kind[i] = $urandom_range(0, 2);
          a[i] = $urandom & 32'hFFFC; d[i] = $urandom;
        end else if (i == w) begin
          v[i] = 1'b0;
        end
      end
      @(negedge clk);
    end
    clr_req();
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_conflict();
    test_fairness();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
